// File: rtl/controlador_pantalla.sv
// Multiplexed 7-segment scan controller with frame-aligned A/B display arbitration.
// Optional leading-zero blanking when SUPRIMIR_CEROS_EN is defined.
module controlador_pantalla #(
  parameter int CANT_CIFRAS = 5,
  parameter int DIV_1MS     = 50000,
  parameter int T_APAGADO   = 8
) (
  input  logic                     reloj,
  input  logic                     reset,
  input  logic                     req_a,
  input  logic [4*CANT_CIFRAS-1:0] dato_a,
  input  logic                     req_b,
  input  logic [4*CANT_CIFRAS-1:0] dato_b,
  output logic                     ack_a,
  output logic                     ack_b,
  output logic                     fuente,
  output logic [3:0]               cifraBCD,
  output logic [CANT_CIFRAS-1:0]   pantalla
);

  localparam int IDX_W = (CANT_CIFRAS > 1) ? $clog2(CANT_CIFRAS) : 1;
  localparam int CNT_W = (DIV_1MS > 1) ? $clog2(DIV_1MS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CANT_CIFRAS - 1);

  typedef enum logic {MOSTRAR = 1'b0, APAGAR = 1'b1} estado_t;

  estado_t                  estado;
  logic [CNT_W-1:0]         presc;
  logic [CNT_W-1:0]         blank_cnt;
  logic [IDX_W-1:0]         idx;
  logic [4*CANT_CIFRAS-1:0] registro;

  logic                     tick;
  logic                     fin_apagado;
  logic                     frontera;
  logic [IDX_W-1:0]         idx_sig;
  logic [4*CANT_CIFRAS-1:0] palabra_sig;
  logic [3:0]               digitos [CANT_CIFRAS];
  logic [CANT_CIFRAS-1:0]   visible;
  logic [CANT_CIFRAS-1:0]   habilita;

  assign tick        = (presc == CNT_W'(DIV_1MS - 1));
  assign fin_apagado = (estado == APAGAR) && (blank_cnt == CNT_W'(T_APAGADO - 1));
  assign frontera    = fin_apagado && (idx == IDX_LAST);
  assign idx_sig     = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Word that will be on display after this edge; lets digit 0 bypass the latch.
  always_comb begin
    palabra_sig = registro;
    if (frontera && req_a)
      palabra_sig = dato_a;
    else if (frontera && req_b)
      palabra_sig = dato_b;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CANT_CIFRAS; gi++) begin : g_cifra
      assign digitos[gi] = palabra_sig[4*gi +: 4];
`ifdef SUPRIMIR_CEROS_EN
      if (gi == 0) begin : g_d0
        assign visible[gi] = 1'b1;
      end else begin : g_dn
        // Digit stays dark when it and everything above it is zero.
        assign visible[gi] = |palabra_sig[4*CANT_CIFRAS-1 : 4*gi];
      end
`else
      assign visible[gi] = 1'b1;
`endif
    end
  endgenerate

  assign habilita = visible & (CANT_CIFRAS'(1) << idx_sig);

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado    <= APAGAR;
      presc     <= '0;
      blank_cnt <= '0;
      idx       <= IDX_LAST;
      registro  <= '0;
      pantalla  <= '1;
      cifraBCD  <= 4'd0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      fuente    <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      presc <= tick ? '0 : presc + 1'b1;
      case (estado)
        MOSTRAR: begin
          if (tick) begin
            estado    <= APAGAR;
            pantalla  <= '1;
            blank_cnt <= '0;
          end
        end
        APAGAR: begin
          if (fin_apagado) begin
            estado   <= MOSTRAR;
            idx      <= idx_sig;
            registro <= palabra_sig;
            pantalla <= ~habilita;
            cifraBCD <= digitos[idx_sig];
            if (frontera) begin
              if (req_a) begin
                fuente <= 1'b0;
                ack_a  <= 1'b1;
              end else if (req_b) begin
                fuente <= 1'b1;
                ack_b  <= 1'b1;
              end
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: estado <= APAGAR;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_pantalla.sv
// Directed bench for controlador_pantalla with CANT_CIFRAS=4, DIV_1MS=10, T_APAGADO=2.
// Edge k after reset: slot (k-2)/10 mod 4 is lit while (k-2) mod 10 < 8; boundaries at k = 2 + 40n.
module tb_controlador_pantalla;

  localparam int N   = 4;
  localparam int DIV = 10;
  localparam int TA  = 2;

  logic        reloj = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] dato_a = 16'h0;
  logic [15:0] dato_b = 16'h0;
  logic        ack_a;
  logic        ack_b;
  logic        fuente;
  logic [3:0]  cifraBCD;
  logic [3:0]  pantalla;

  int checks = 0;
  int errors = 0;

  controlador_pantalla #(.CANT_CIFRAS(N), .DIV_1MS(DIV), .T_APAGADO(TA)) dut (
    .reloj(reloj), .reset(reset),
    .req_a(req_a), .dato_a(dato_a),
    .req_b(req_b), .dato_b(dato_b),
    .ack_a(ack_a), .ack_b(ack_b), .fuente(fuente),
    .cifraBCD(cifraBCD), .pantalla(pantalla)
  );

  always #5 reloj = ~reloj;

  function automatic int slot_of(int k);
    if (k < 2) return -1;
    if (((k - 2) % 10) >= 8) return -1;
    return ((k - 2) / 10) % 4;
  endfunction

  function automatic logic [3:0] digit_of(logic [15:0] w, int s);
    return w[4*s +: 4];
  endfunction

  function automatic logic [3:0] exp_pan(int k, logic [15:0] w);
    int s;
    logic [3:0] p;
    s = slot_of(k);
    p = 4'hF;
    if (s >= 0) begin
      p[s] = 1'b0;
`ifdef SUPRIMIR_CEROS_EN
      if (s > 0 && (w >> (4*s)) == 16'h0) p = 4'hF;
`endif
    end
    return p;
  endfunction

  task automatic step();
    @(posedge reloj);
    @(negedge reloj);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_a = 0; req_b = 0;
    do_reset();
    checks++; if (pantalla !== 4'hF) begin errors++; $display("FAIL reset_pantalla got %b want 1111", pantalla); end
    checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL reset_cifra got %h want 0", cifraBCD); end
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL reset_ack_a got %b want 0", ack_a); end
    checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL reset_ack_b got %b want 0", ack_b); end
    checks++; if (fuente !== 1'b0) begin errors++; $display("FAIL reset_fuente got %b want 0", fuente); end
    step();
    checks++; if (pantalla !== 4'hF) begin errors++; $display("FAIL reset_blank1 got %b want 1111", pantalla); end
    step();
    checks++; if (pantalla !== 4'b1110) begin errors++; $display("FAIL reset_first_slot got %b want 1110", pantalla); end
    checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL reset_first_cifra got %h want 0", cifraBCD); end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    req_a = 0; req_b = 0;
    do_reset();
    for (int k = 1; k <= 84; k++) begin
      step();
      checks++; if (pantalla !== exp_pan(k, 16'h0)) begin errors++; $display("FAIL scan_pantalla k=%0d got %b want %b", k, pantalla, exp_pan(k, 16'h0)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL scan_cifra k=%0d got %h want 0", k, cifraBCD); end
      end
      checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL scan_acks k=%0d got %b want 00", k, {ack_a, ack_b}); end
    end
    $display("test_scan done");
  endtask

  task automatic test_req_a();
    logic [15:0] w;
    req_a = 1; dato_a = 16'h1234; req_b = 0;
    do_reset();
    for (int k = 1; k <= 84; k++) begin
      step();
      w = (k >= 2) ? 16'h1234 : 16'h0;
      checks++; if (ack_a !== (k == 2)) begin errors++; $display("FAIL reqa_ack_a k=%0d got %b want %b", k, ack_a, (k == 2)); end
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL reqa_ack_b k=%0d got %b want 0", k, ack_b); end
      checks++; if (pantalla !== exp_pan(k, w)) begin errors++; $display("FAIL reqa_pantalla k=%0d got %b want %b", k, pantalla, exp_pan(k, w)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== digit_of(w, slot_of(k))) begin errors++; $display("FAIL reqa_cifra k=%0d got %h want %h", k, cifraBCD, digit_of(w, slot_of(k))); end
      end
      checks++; if (fuente !== 1'b0) begin errors++; $display("FAIL reqa_fuente k=%0d got %b want 0", k, fuente); end
      if (k == 2) req_a = 0;
    end
    $display("test_req_a done");
  endtask

  task automatic test_a_then_b();
    logic [15:0] w;
    req_a = 1; dato_a = 16'h1234; req_b = 1; dato_b = 16'h0987;
    do_reset();
    for (int k = 1; k <= 84; k++) begin
      step();
      w = (k >= 42) ? 16'h0987 : ((k >= 2) ? 16'h1234 : 16'h0);
      checks++; if (ack_a !== (k == 2)) begin errors++; $display("FAIL ab_ack_a k=%0d got %b want %b", k, ack_a, (k == 2)); end
      checks++; if (ack_b !== (k == 42)) begin errors++; $display("FAIL ab_ack_b k=%0d got %b want %b", k, ack_b, (k == 42)); end
      checks++; if (fuente !== (k >= 42)) begin errors++; $display("FAIL ab_fuente k=%0d got %b want %b", k, fuente, (k >= 42)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== digit_of(w, slot_of(k))) begin errors++; $display("FAIL ab_cifra k=%0d got %h want %h", k, cifraBCD, digit_of(w, slot_of(k))); end
      end
      if (k == 2) req_a = 0;
      if (k == 42) req_b = 0;
    end
    $display("test_a_then_b done");
  endtask

  task automatic test_back_to_back();
    req_a = 1; dato_a = 16'h1234; req_b = 0;
    do_reset();
    for (int k = 1; k <= 84; k++) begin
      step();
      checks++; if (ack_a !== (k == 2 || k == 42 || k == 82)) begin errors++; $display("FAIL held_ack_a k=%0d got %b want %b", k, ack_a, (k == 2 || k == 42 || k == 82)); end
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL held_ack_b k=%0d got %b want 0", k, ack_b); end
    end
    req_a = 0;
    $display("test_back_to_back done");
  endtask

  task automatic test_mid_frame_b();
    logic [15:0] w;
    req_a = 0; req_b = 0; dato_b = 16'h0;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      step();
      w = (k >= 42) ? 16'h0987 : 16'h0;
      checks++; if (ack_b !== (k == 42)) begin errors++; $display("FAIL mid_ack_b k=%0d got %b want %b", k, ack_b, (k == 42)); end
      checks++; if (fuente !== (k >= 42)) begin errors++; $display("FAIL mid_fuente k=%0d got %b want %b", k, fuente, (k >= 42)); end
      checks++; if (pantalla !== exp_pan(k, w)) begin errors++; $display("FAIL mid_pantalla k=%0d got %b want %b", k, pantalla, exp_pan(k, w)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== digit_of(w, slot_of(k))) begin errors++; $display("FAIL mid_cifra k=%0d got %h want %h", k, cifraBCD, digit_of(w, slot_of(k))); end
      end
      if (k == 25) begin req_b = 1; dato_b = 16'h0987; end
      if (k == 42) req_b = 0;
    end
    $display("test_mid_frame_b done");
  endtask

  task automatic test_withdraw();
    req_a = 0; req_b = 0;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      step();
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL wd_ack_b k=%0d got %b want 0", k, ack_b); end
      checks++; if (fuente !== 1'b0) begin errors++; $display("FAIL wd_fuente k=%0d got %b want 0", k, fuente); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL wd_cifra k=%0d got %h want 0", k, cifraBCD); end
      end
      if (k == 5) begin req_b = 1; dato_b = 16'h0987; end
      if (k == 30) req_b = 0;
    end
    $display("test_withdraw done");
  endtask

  task automatic test_reset_mid();
    req_a = 0; req_b = 1; dato_b = 16'h5555;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 2) req_b = 0;
    end
    checks++; if (pantalla !== 4'b1101) begin errors++; $display("FAIL rm_pre_pantalla got %b want 1101", pantalla); end
    checks++; if (cifraBCD !== 4'h5) begin errors++; $display("FAIL rm_pre_cifra got %h want 5", cifraBCD); end
    checks++; if (fuente !== 1'b1) begin errors++; $display("FAIL rm_pre_fuente got %b want 1", fuente); end
    do_reset();
    checks++; if (pantalla !== 4'hF) begin errors++; $display("FAIL rm_pantalla got %b want 1111", pantalla); end
    checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL rm_cifra got %h want 0", cifraBCD); end
    checks++; if (fuente !== 1'b0) begin errors++; $display("FAIL rm_fuente got %b want 0", fuente); end
    for (int k = 1; k <= 44; k++) begin
      step();
      checks++; if (pantalla !== exp_pan(k, 16'h0)) begin errors++; $display("FAIL rm_post_pantalla k=%0d got %b want %b", k, pantalla, exp_pan(k, 16'h0)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== 4'h0) begin errors++; $display("FAIL rm_post_cifra k=%0d got %h want 0", k, cifraBCD); end
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_ceros();
    logic [15:0] w;
    req_a = 1; dato_a = 16'h0070; req_b = 0;
    do_reset();
    for (int k = 1; k <= 42; k++) begin
      step();
      w = (k >= 2) ? 16'h0070 : 16'h0;
      checks++; if (pantalla !== exp_pan(k, w)) begin errors++; $display("FAIL ceros_pantalla k=%0d got %b want %b", k, pantalla, exp_pan(k, w)); end
      if (slot_of(k) >= 0) begin
        checks++; if (cifraBCD !== digit_of(w, slot_of(k))) begin errors++; $display("FAIL ceros_cifra k=%0d got %h want %h", k, cifraBCD, digit_of(w, slot_of(k))); end
      end
      if (k == 2) req_a = 0;
    end
    $display("test_ceros done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_req_a();
    test_a_then_b();
    test_back_to_back();
    test_mid_frame_b();
    test_withdraw();
    test_reset_mid();
    test_ceros();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
